delay_stats: RTL and testbench
==============================

Name: delay_stats

Overview:
- Downstream consumer of the frame-delay timer in the delay tester.
- Accepts one latency sample (timer ticks between frame_sent and frame_caught) per valid pulse, plus a lost-frame pulse when a frame never returns.
- Accumulates count, lost count, sum, min and max.
- On request, freezes a snapshot and computes the integer average with a serial divider, for readout by the host/display logic.

Parameters:
DW, 20, latency sample width (matches timer counter width)
CW, 16, width of sample and lost counters
SW, DW+CW, width of running sum and divider iteration count

Ports:
tx_clk  in  1  clock; all logic on rising edge
reset  in  1  asynchronous, active-high; clears everything
dif_valid  in  1  one-cycle pulse, dif_in holds a new latency sample
dif_in  in  DW  latency sample in tx_clk ticks
dif_lost  in  1  one-cycle pulse, one frame timed out
clear  in  1  one-cycle pulse, zero all accumulators
snap_req  in  1  one-cycle pulse, request snapshot plus average
busy  out  1  snapshot/division in progress
stat_valid  out  1  one-cycle pulse, stat_* outputs freshly updated
stat_min  out  DW  minimum sample of snapshot
stat_max  out  DW  maximum sample of snapshot
stat_avg  out  DW  floor(sum/count) of snapshot
stat_cnt  out  CW  samples counted in snapshot
stat_lost  out  CW  lost frames in snapshot
stat_ovf  out  1  sample counter saturated in snapshot

Behaviour:
- Reset: all outputs 0. Accumulators: cnt=0, lost=0, sum=0, max=0, ovf=0, min=all-ones. FSM to IDLE.
- Sample (dif_valid=1, clear=0):
  - if cnt==2^CW-1: sample dropped, ovf set (sticky until clear/reset);
  - else cnt+=1, sum+=dif_in, min=min(min,dif_in), max=max(max,dif_in); all update on the same edge.
  - sum cannot overflow: SW=DW+CW.
- dif_lost: lost+=1, saturating at 2^CW-1.
- dif_valid and dif_lost in the same cycle: both applied.
- clear: accumulators return to reset values on the next edge.
  - clear wins over same-cycle dif_valid/dif_lost; those events are discarded.
  - clear does not affect a snapshot in progress or the stat_* outputs.
- FSM states IDLE, DIV, DONE:
  - IDLE: snap_req=1 -> latch cnt/lost/sum/min/max/ovf into snapshot registers. Values captured are those before any same-cycle sample update; that sample still goes into the live accumulators. busy=1 from this edge; go to DIV.
  - DIV: restoring division of snapshot sum by snapshot cnt, one quotient bit per cycle, MSB first, exactly SW cycles; then DONE.
  - DONE: register stat_* from snapshot and quotient (low DW bits; quotient <= max so it fits). Assert stat_valid for one cycle, drop busy, return to IDLE.
- Latency: stat_valid is high in the cycle after the (SW+2)th edge following the edge that samples snap_req. Constant, independent of data.
- Snapshot cnt==0: stat_avg=0, stat_min=0 (not all-ones), stat_max=0. Latency unchanged; no divide-by-zero.
- snap_req while busy: ignored, no queueing.
- Live accumulation continues during DIV/DONE.
- stat_* hold their last values until the next DONE.
- Reset mid-division: immediate abort, all outputs 0, FSM IDLE, no stat_valid.

Test Plan:
- Samples 100, 300, 200, then snap_req -> after SW+2 edges: stat_valid one cycle; min=100, max=300, avg=200, cnt=3, lost=0, ovf=0; busy high throughout the division.
- Snapshot with no samples after reset -> stat_min=0, stat_max=0, stat_avg=0, stat_cnt=0, same latency; samples 1 and 2 -> avg=1 (truncation).
- CW=4 build: 16 samples of value 5 -> cnt=15, sum=75, avg=5, ovf=1; clear then 1 sample of 7 -> cnt=1, ovf=0, min=max=avg=7.
- dif_valid=1 with dif_in=50 and dif_lost=1 in the same cycle -> cnt=1, lost=1. clear with dif_valid=1, dif_in=9 in the same cycle -> snapshot shows cnt=0, min=0.
- snap_req, then a second snap_req 5 cycles later, then sample 1000 during DIV -> exactly one stat_valid; snapshot excludes 1000; a later snapshot includes 1000 as max.
- Assert reset 10 cycles into DIV -> busy=0, all stat_*=0 immediately; no stat_valid; next snap_req completes normally.

Source files
------------

// File: rtl/delay_stats.sv
// Latency statistics for the frame-delay tester: live count/lost/sum/min/max
// accumulation plus an on-demand frozen snapshot with a serial restoring divider.
module delay_stats #(
  parameter int DW = 20,
  parameter int CW = 16,
  parameter int SW = DW + CW
) (
  input  logic          tx_clk,
  input  logic          reset,
  input  logic          dif_valid,
  input  logic [DW-1:0] dif_in,
  input  logic          dif_lost,
  input  logic          clear,
  input  logic          snap_req,
  output logic          busy,
  output logic          stat_valid,
  output logic [DW-1:0] stat_min,
  output logic [DW-1:0] stat_max,
  output logic [DW-1:0] stat_avg,
  output logic [CW-1:0] stat_cnt,
  output logic [CW-1:0] stat_lost,
  output logic          stat_ovf
);

  localparam int BW = $clog2(SW + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_lost;
  logic [SW-1:0] r_sum;
  logic [DW-1:0] r_min;
  logic [DW-1:0] r_max;
  logic          r_ovf;

  state_t        r_state;
  logic [BW-1:0] r_bit;
  logic [CW-1:0] r_s_cnt;
  logic [CW-1:0] r_s_lost;
  logic [DW-1:0] r_s_min;
  logic [DW-1:0] r_s_max;
  logic          r_s_ovf;
  logic [SW-1:0] r_quo;
  logic [CW-1:0] r_rem;

  logic [CW:0]   w_rem_sh;
  logic          w_ge;
  logic [CW-1:0] w_sub;

  // Live accumulators; clear takes priority over same-cycle events
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_lost <= '0;
      r_sum  <= '0;
      r_min  <= '1;
      r_max  <= '0;
      r_ovf  <= 1'b0;
    end else if (clear) begin
      r_cnt  <= '0;
      r_lost <= '0;
      r_sum  <= '0;
      r_min  <= '1;
      r_max  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (dif_valid) begin
        if (r_cnt == CNT_MAX) begin
          r_ovf <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
          r_sum <= r_sum + SW'(dif_in);
          if (dif_in < r_min) r_min <= dif_in;
          if (dif_in > r_max) r_max <= dif_in;
        end
      end
      if (dif_lost && (r_lost != CNT_MAX)) r_lost <= r_lost + CW'(1);
    end
  end

  // One restoring-division step: the partial remainder never exceeds the
  // divisor, so the subtraction result always fits in CW bits.
  always_comb begin
    w_rem_sh = {r_rem, r_quo[SW-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_s_cnt});
    w_sub    = w_rem_sh[CW-1:0] - r_s_cnt;
  end

  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bit      <= '0;
      r_s_cnt    <= '0;
      r_s_lost   <= '0;
      r_s_min    <= '0;
      r_s_max    <= '0;
      r_s_ovf    <= 1'b0;
      r_quo      <= '0;
      r_rem      <= '0;
      busy       <= 1'b0;
      stat_valid <= 1'b0;
      stat_min   <= '0;
      stat_max   <= '0;
      stat_avg   <= '0;
      stat_cnt   <= '0;
      stat_lost  <= '0;
      stat_ovf   <= 1'b0;
    end else begin
      stat_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (snap_req) begin
            r_s_cnt  <= r_cnt;
            r_s_lost <= r_lost;
            r_s_min  <= r_min;
            r_s_max  <= r_max;
            r_s_ovf  <= r_ovf;
            r_quo    <= r_sum;
            r_rem    <= '0;
            r_bit    <= BW'(SW);
            busy     <= 1'b1;
            r_state  <= S_DIV;
          end
        end
        S_DIV: begin
          if (r_bit != '0) begin
            r_rem <= w_ge ? w_sub : w_rem_sh[CW-1:0];
            r_quo <= {r_quo[SW-2:0], w_ge};
            r_bit <= r_bit - BW'(1);
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // An empty snapshot reports zeros instead of the all-ones min seed
          stat_min   <= (r_s_cnt == '0) ? '0 : r_s_min;
          stat_max   <= r_s_max;
          stat_avg   <= (r_s_cnt == '0) ? '0 : r_quo[DW-1:0];
          stat_cnt   <= r_s_cnt;
          stat_lost  <= r_s_lost;
          stat_ovf   <= r_s_ovf;
          stat_valid <= 1'b1;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_stats.sv
// Bench for delay_stats: two instances (CW=16 and CW=4) share stimulus and are
// checked every cycle against a queue-based model of the accumulated samples.
module tb_delay_stats;

  localparam int DW  = 20;
  localparam int CW0 = 16;
  localparam int CW1 = 4;
  localparam int SW0 = DW + CW0;
  localparam int SW1 = DW + CW1;

  logic          tx_clk = 1'b0;
  logic          reset;
  logic          dif_valid, dif_lost, clear, snap_req;
  logic [DW-1:0] dif_in;

  logic           busy0, sv0, ovf0;
  logic [DW-1:0]  min0, max0, avg0;
  logic [CW0-1:0] cnt0, lost0;
  logic           busy1, sv1, ovf1;
  logic [DW-1:0]  min1, max1, avg1;
  logic [CW1-1:0] cnt1, lost1;

  always #5 tx_clk = ~tx_clk;

  delay_stats #(.DW(DW), .CW(CW0)) u_dut0 (
    .tx_clk(tx_clk), .reset(reset), .dif_valid(dif_valid), .dif_in(dif_in),
    .dif_lost(dif_lost), .clear(clear), .snap_req(snap_req), .busy(busy0),
    .stat_valid(sv0), .stat_min(min0), .stat_max(max0), .stat_avg(avg0),
    .stat_cnt(cnt0), .stat_lost(lost0), .stat_ovf(ovf0));

  delay_stats #(.DW(DW), .CW(CW1)) u_dut1 (
    .tx_clk(tx_clk), .reset(reset), .dif_valid(dif_valid), .dif_in(dif_in),
    .dif_lost(dif_lost), .clear(clear), .snap_req(snap_req), .busy(busy1),
    .stat_valid(sv1), .stat_min(min1), .stat_max(max1), .stat_avg(avg1),
    .stat_cnt(cnt1), .stat_lost(lost1), .stat_ovf(ovf1));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: accepted samples since the last clear, per instance
  int unsigned mq0[$];
  int unsigned mq1[$];
  int unsigned mlost[2];
  bit          movf[2];
  bit          pend[2];
  int          due[2];
  longint unsigned e_min[2], e_max[2], e_avg[2], e_cnt[2], e_lost[2];
  bit          e_ovf[2];
  int unsigned cmax[2] = '{(1 << CW0) - 1, (1 << CW1) - 1};
  int          swv[2]  = '{SW0, SW1};

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    for (int i = 0; i < 2; i++) begin
      mlost[i] = 0; movf[i] = 0; pend[i] = 0;
      e_min[i] = 0; e_max[i] = 0; e_avg[i] = 0; e_cnt[i] = 0; e_lost[i] = 0; e_ovf[i] = 0;
    end
  endtask

  task automatic take_snapshot(input int i);
    int unsigned q[$];
    longint unsigned sum, mn, mx;
    q = (i == 0) ? mq0 : mq1;
    sum = 0; mn = 64'hFFFF_FFFF; mx = 0;
    foreach (q[k]) begin
      sum += q[k];
      if (q[k] < mn) mn = q[k];
      if (q[k] > mx) mx = q[k];
    end
    e_cnt[i]  = q.size();
    e_min[i]  = (q.size() == 0) ? 0 : mn;
    e_max[i]  = mx;
    e_avg[i]  = (q.size() == 0) ? 0 : sum / q.size();
    e_lost[i] = mlost[i];
    e_ovf[i]  = movf[i];
    pend[i]   = 1;
    due[i]    = cyc + swv[i] + 2;
  endtask

  task automatic model_edge(input bit v, input int unsigned d, input bit l, input bit c, input bit s);
    for (int i = 0; i < 2; i++) begin
      if (s && !pend[i]) take_snapshot(i);
      if (c) begin
        if (i == 0) mq0.delete(); else mq1.delete();
        mlost[i] = 0;
        movf[i]  = 0;
      end else begin
        if (v) begin
          if (((i == 0) ? mq0.size() : mq1.size()) >= cmax[i]) movf[i] = 1;
          else if (i == 0) mq0.push_back(d);
          else mq1.push_back(d);
        end
        if (l && mlost[i] < cmax[i]) mlost[i]++;
      end
    end
  endtask

  task automatic check_fields(input int i, input string pfx);
    check({pfx, "_min"},  (i == 0) ? 64'(min0)  : 64'(min1),  e_min[i]);
    check({pfx, "_max"},  (i == 0) ? 64'(max0)  : 64'(max1),  e_max[i]);
    check({pfx, "_avg"},  (i == 0) ? 64'(avg0)  : 64'(avg1),  e_avg[i]);
    check({pfx, "_cnt"},  (i == 0) ? 64'(cnt0)  : 64'(cnt1),  e_cnt[i]);
    check({pfx, "_lost"}, (i == 0) ? 64'(lost0) : 64'(lost1), e_lost[i]);
    check({pfx, "_ovf"},  (i == 0) ? 64'(ovf0)  : 64'(ovf1),  64'(e_ovf[i]));
  endtask

  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      string p = (i == 0) ? "d0" : "d1";
      if (pend[i] && cyc == due[i]) begin
        check({p, "_valid"}, (i == 0) ? 64'(sv0) : 64'(sv1), 64'd1);
        check_fields(i, p);
        pend[i] = 0;
      end else begin
        check({p, "_valid"}, (i == 0) ? 64'(sv0) : 64'(sv1), 64'd0);
      end
      check({p, "_busy"}, (i == 0) ? 64'(busy0) : 64'(busy1), 64'(pend[i]));
    end
  endtask

  task automatic step(input bit v, input int unsigned d, input bit l, input bit c, input bit s);
    dif_valid = v; dif_in = d[DW-1:0]; dif_lost = l; clear = c; snap_req = s;
    @(posedge tx_clk);
    cyc++;
    model_edge(v, d & ((1 << DW) - 1), l, c, s);
    #1;
    dif_valid = 0; dif_lost = 0; clear = 0; snap_req = 0;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  task automatic sample(input int unsigned d);
    step(1, d, 0, 0, 0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once
  task automatic do_reset();
    #2;
    reset = 1;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      string p = (i == 0) ? "rst0" : "rst1";
      check({p, "_busy"},  (i == 0) ? 64'(busy0) : 64'(busy1), 64'd0);
      check({p, "_valid"}, (i == 0) ? 64'(sv0)   : 64'(sv1),   64'd0);
      check_fields(i, p);
    end
    @(posedge tx_clk);
    @(negedge tx_clk);
    reset = 0;
    @(posedge tx_clk);
    #1;
  endtask

  initial begin
    reset = 1; dif_valid = 0; dif_in = '0; dif_lost = 0; clear = 0; snap_req = 0;
    model_reset();
    #3;
    for (int i = 0; i < 2; i++) check_fields(i, (i == 0) ? "init0" : "init1");
    check("init_busy", 64'(busy0), 64'd0);
    @(negedge tx_clk);
    reset = 0;
    @(posedge tx_clk);
    #1;

    // Basic average
    sample(100); sample(300); sample(200);
    step(0, 0, 0, 0, 1);
    check("t1_busy_start", 64'(busy0), 64'd1);
    idle(40);
    check("t1_min", 64'(min0), 64'd100);
    check("t1_max", 64'(max0), 64'd300);
    check("t1_avg", 64'(avg0), 64'd200);
    check("t1_cnt", 64'(cnt0), 64'd3);

    // Empty snapshot, then truncating average
    do_reset();
    step(0, 0, 0, 0, 1);
    idle(40);
    check("t2_min_empty", 64'(min0), 64'd0);
    sample(1); sample(2);
    step(0, 0, 0, 0, 1);
    idle(40);
    check("t2_avg_trunc", 64'(avg0), 64'd1);

    // Sample counter saturation on the CW=4 instance
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 16; k++) sample(5);
    step(0, 0, 0, 0, 1);
    idle(40);
    check("t3_cnt_sat", 64'(cnt1), 64'd15);
    check("t3_ovf", 64'(ovf1), 64'd1);
    check("t3_avg", 64'(avg1), 64'd5);
    step(0, 0, 0, 1, 0);
    sample(7);
    step(0, 0, 0, 0, 1);
    idle(40);
    check("t3_ovf_clr", 64'(ovf1), 64'd0);
    check("t3_avg7", 64'(avg1), 64'd7);

    // Simultaneous sample+lost, then clear beating a sample
    step(0, 0, 0, 1, 0);
    step(1, 50, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    idle(40);
    check("t4_lost", 64'(lost0), 64'd1);
    step(1, 9, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    idle(40);
    check("t4_clr_cnt", 64'(cnt0), 64'd0);

    // Snapshot requests while busy are dropped; live accumulation continues
    step(0, 0, 0, 1, 0);
    sample(10); sample(20);
    step(0, 0, 0, 0, 1);
    idle(4);
    step(0, 0, 0, 0, 1);
    sample(1000);
    idle(40);
    check("t5_max_excl", 64'(max0), 64'd20);
    step(0, 0, 0, 0, 1);
    idle(40);
    check("t5_max_incl", 64'(max0), 64'd1000);

    // Reset mid-division, then a normal snapshot
    step(0, 0, 0, 0, 1);
    idle(10);
    do_reset();
    sample(42);
    step(0, 0, 0, 0, 1);
    idle(40);
    check("t6_after_rst", 64'(avg0), 64'd42);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit v, l, c, s;
      int unsigned d;
      v = ($urandom_range(0, 2) == 0);
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, (1 << DW) - 1);
      l = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 24) == 0);
      step(v, d, l, c, s);
    end
    idle(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
